// File: rtl/tl_sink_id_allocator.sv
// Sink ID pool for a TileLink manager: round-robin grant of the
// lowest free ID, returned on GrantAck, sticky error on bad frees.
module tl_sink_id_allocator #(
  parameter int SinkWidth = 2,
  parameter int NumReq    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [SinkWidth-1:0]    req_sink_o,
  input  logic                    e_valid_i,
  input  logic [SinkWidth-1:0]    e_sink_i,
  output logic                    e_ready_o,
  output logic [2**SinkWidth-1:0] busy_o,
  output logic [SinkWidth:0]      free_count_o,
  output logic                    err_o
);

  localparam int NumSinks = 2**SinkWidth;
  localparam int PtrW     = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam int CntW     = SinkWidth + 1;

  logic [NumSinks-1:0]  busy_q, busy_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;

  logic [PtrW-1:0]      win_hi, win_lo, winner;
  logic                 found_hi, found_lo;
  logic [SinkWidth-1:0] free_id;
  logic                 pool_full;
  logic                 grant_ok;
  logic                 hs;
  logic [CntW-1:0]      free_cnt;

  // Lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NumReq-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        win_lo   = PtrW'(i);
        found_lo = 1'b1;
        if (PtrW'(i) >= rr_ptr_q) begin
          win_hi   = PtrW'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    free_id  = '0;
    free_cnt = '0;
    for (int j = NumSinks-1; j >= 0; j--) begin
      if (!busy_q[j]) begin
        free_id = SinkWidth'(j);
      end
      free_cnt = free_cnt + CntW'(!busy_q[j]);
    end
    pool_full = &busy_q;
  end

  assign grant_ok = found_lo && !pool_full;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = grant_ok && (winner == PtrW'(i));
    end
  end

  assign hs = |(req_valid_i & req_ready_o);

  // Free check uses busy_q, so a same-cycle allocation never collides.
  always_comb begin
    busy_d   = busy_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    if (e_valid_i) begin
      if (busy_q[e_sink_i]) begin
        busy_d[e_sink_i] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (hs) begin
      busy_d[free_id] = 1'b1;
      if (winner == PtrW'(NumReq-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign req_sink_o   = free_id;
  assign e_ready_o    = 1'b1;
  assign busy_o       = busy_q;
  assign free_count_o = free_cnt;
  assign err_o        = err_q;

endmodule
